// File: rtl/pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// pipe_skid_reg
//
// Purpose:
//   A two-entry pipeline register with a skid buffer. The main entry drives
//   data_o/valid_o. The skid entry catches the one item that can arrive in the
//   cycle after downstream stops accepting. ready_o comes only from the skid
//   valid flop, so upstream sees no combinational path from ready_i, stall_i
//   or flush_i.
//   stall_i freezes the whole stage and takes priority over flush_i. flush_i
//   discards both entries and the incoming item, and leaves a NOP bubble
//   (FLUSH_DATA) on data_o.
//
// Optional feature:
//   PIPE_SKID_REG_STATS_EN -- when defined, builds saturating stall and flush
//   counters. When undefined, stall_cnt_o and flush_cnt_o are tied to zero.
//
// Ports:
//   clk_i        in   1       clock, posedge
//   rst_i        in   1       asynchronous active-high reset
//   valid_i      in   1       upstream item present
//   data_i       in   DATA_W  upstream payload
//   ready_o      out  1       stage can accept an item this cycle
//   valid_o      out  1       downstream item present
//   data_o       out  DATA_W  downstream payload
//   ready_i      in   1       downstream accepts this cycle
//   stall_i      in   1       hazard hold, freezes the stage
//   flush_i      in   1       discard held and incoming items
//   stall_cnt_o  out  CNT_W   cycles with a blocked output item
//   flush_cnt_o  out  CNT_W   effective flushes
// -----------------------------------------------------------------------------
module pipe_skid_reg #(
    parameter int                DATA_W     = 64,
    parameter logic [DATA_W-1:0] FLUSH_DATA = {DATA_W{1'b1}},
    parameter int                CNT_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    output logic              ready_o,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    input  logic              ready_i,
    input  logic              stall_i,
    input  logic              flush_i,
    output logic [CNT_W-1:0]  stall_cnt_o,
    output logic [CNT_W-1:0]  flush_cnt_o
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;

    logic [DATA_W-1:0] r_main_data;
    logic              r_main_vld;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_skid_vld;

    logic [DATA_W-1:0] w_main_data_nxt;
    logic              w_main_vld_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic              w_skid_vld_nxt;

    logic              w_accept;
    logic              w_drain;
    logic              w_flush;

    // Handshake qualifiers. Stall gates all three, which gives stall its
    // priority over flush without a separate branch in the FSM.
    assign w_accept = valid_i & ~r_skid_vld & ~stall_i & ~flush_i;
    assign w_drain  = r_main_vld & ready_i & ~stall_i;
    assign w_flush  = flush_i & ~stall_i;

    assign ready_o  = ~r_skid_vld;
    assign valid_o  = r_main_vld;
    assign data_o   = r_main_data;

    // State and datapath registers
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_vld  <= 1'b0;
            r_skid_data <= '0;
            r_skid_vld  <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_data_nxt;
            r_main_vld  <= w_main_vld_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_vld  <= w_skid_vld_nxt;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        w_state_nxt     = r_state;
        w_main_data_nxt = r_main_data;
        w_main_vld_nxt  = r_main_vld;
        w_skid_data_nxt = r_skid_data;
        w_skid_vld_nxt  = r_skid_vld;

        if (w_flush) begin
            w_state_nxt     = ST_EMPTY;
            w_main_vld_nxt  = 1'b0;
            w_main_data_nxt = FLUSH_DATA;
            w_skid_vld_nxt  = 1'b0;
        end else begin
            unique case (r_state)
                ST_EMPTY: begin
                    if (w_accept) begin
                        w_main_data_nxt = data_i;
                        w_main_vld_nxt  = 1'b1;
                        w_state_nxt     = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (w_accept && w_drain) begin
                        // Pass-through: the new item replaces the leaving one.
                        w_main_data_nxt = data_i;
                    end else if (w_accept) begin
                        // Output is blocked, so park the new item in the skid entry.
                        w_skid_data_nxt = data_i;
                        w_skid_vld_nxt  = 1'b1;
                        w_state_nxt     = ST_FULL;
                    end else if (w_drain) begin
                        // data_o keeps its last value, and only valid drops.
                        w_main_vld_nxt  = 1'b0;
                        w_state_nxt     = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // ready_o is low here, so no accept can happen.
                    if (w_drain) begin
                        w_main_data_nxt = r_skid_data;
                        w_skid_vld_nxt  = 1'b0;
                        w_state_nxt     = ST_ONE;
                    end
                end
                default: begin
                    w_state_nxt     = ST_EMPTY;
                    w_main_vld_nxt  = 1'b0;
                    w_skid_vld_nxt  = 1'b0;
                end
            endcase
        end
    end

`ifdef PIPE_SKID_REG_STATS_EN
    logic [CNT_W-1:0] r_stall_cnt;
    logic [CNT_W-1:0] r_flush_cnt;
    logic             w_stall_evt;

    // The output holds an item that cannot leave this cycle.
    assign w_stall_evt = r_main_vld & (~ready_i | stall_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (w_stall_evt && (r_stall_cnt != {CNT_W{1'b1}}))
                r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_flush && (r_flush_cnt != {CNT_W{1'b1}}))
                r_flush_cnt <= r_flush_cnt + 1'b1;
        end
    end

    assign stall_cnt_o = r_stall_cnt;
    assign flush_cnt_o = r_flush_cnt;
`else
    assign stall_cnt_o = '0;
    assign flush_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_skid_reg.sv
// -----------------------------------------------------------------------------
// tb_pipe_skid_reg
//
// Scoreboard bench for pipe_skid_reg. The stimulus process pushes the expected
// payload of every item it hands over. The monitor pops one entry and compares
// it against data_o on every drain cycle. State checks (ready/valid, flush
// bubble, reset, counters) are directed.
// A second instance with CNT_W=2 exercises counter saturation.
// -----------------------------------------------------------------------------
module tb_pipe_skid_reg;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        valid_i = 1'b0;
    logic [63:0] data_i = '0;
    logic        ready_o;
    logic        valid_o;
    logic [63:0] data_o;
    logic        ready_i = 1'b0;
    logic        stall_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    // Small instance used only for saturation
    logic        v2 = 1'b0;
    logic [7:0]  d2 = '0;
    logic        rdy_o2;
    logic        vld_o2;
    logic [7:0]  dat_o2;
    logic        r2 = 1'b0;
    logic        s2 = 1'b0;
    logic        f2 = 1'b0;
    logic [1:0]  scnt2;
    logic [1:0]  fcnt2;

`ifdef PIPE_SKID_REG_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];

    pipe_skid_reg dut (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .data_i(data_i),
        .ready_o(ready_o), .valid_o(valid_o), .data_o(data_o),
        .ready_i(ready_i), .stall_i(stall_i), .flush_i(flush_i),
        .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
    );

    pipe_skid_reg #(.DATA_W(8), .CNT_W(2)) dut2 (
        .clk_i(clk_i), .rst_i(rst_i), .valid_i(v2), .data_i(d2),
        .ready_o(rdy_o2), .valid_o(vld_o2), .data_o(dat_o2),
        .ready_i(r2), .stall_i(s2), .flush_i(f2),
        .stall_cnt_o(scnt2), .flush_cnt_o(fcnt2)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        valid_i = 1'b0; ready_i = 1'b0; stall_i = 1'b0; flush_i = 1'b0;
        v2 = 1'b0; r2 = 1'b0; s2 = 1'b0; f2 = 1'b0;
        exp_q.delete();
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    // Monitor: every drain cycle must carry the oldest expected item.
    initial begin
        logic [63:0] e;
        forever begin
            @(negedge clk_i);
            if (!rst_i && valid_o && ready_i && !stall_i) begin
                if (exp_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL drain_unexpected: got %h want none", data_o);
                end else begin
                    e = exp_q.pop_front();
                    chk("drain_data", data_o, e);
                end
            end
        end
    end

    initial begin
        // Reset values
        #1;
        chk("rst_valid", {63'd0, valid_o}, 64'd0);
        chk("rst_data", data_o, 64'd0);
        chk("rst_ready", {63'd0, ready_o}, 64'd1);
        chk("rst_scnt", {48'd0, stall_cnt_o}, 64'd0);
        chk("rst_fcnt", {48'd0, flush_cnt_o}, 64'd0);
        tick();
        tick();
        rst_i = 1'b0;

        // Single item through an empty stage
        valid_i = 1'b1; data_i = 64'h11; ready_i = 1'b1; exp_q.push_back(64'h11);
        tick();
        valid_i = 1'b0;
        chk("single_valid", {63'd0, valid_o}, 64'd1);
        chk("single_data", data_o, 64'h11);
        tick();
        chk("single_gone", {63'd0, valid_o}, 64'd0);

        // Fill the skid entry, then release
        ready_i = 1'b0;
        valid_i = 1'b1; data_i = 64'hA; exp_q.push_back(64'hA);
        tick();
        data_i = 64'hB; exp_q.push_back(64'hB);
        tick();
        valid_i = 1'b0;
        chk("full_ready", {63'd0, ready_o}, 64'd0);
        chk("full_valid", {63'd0, valid_o}, 64'd1);
        chk("full_data", data_o, 64'hA);
        ready_i = 1'b1;
        tick();
        chk("release_ready", {63'd0, ready_o}, 64'd1);
        chk("release_data", data_o, 64'hB);
        tick();
        chk("empty_valid", {63'd0, valid_o}, 64'd0);
        chk("empty_data_kept", data_o, 64'hB);

        // Back-to-back stream at full rate
        for (int k = 0; k < 4; k++) begin
            valid_i = 1'b1; data_i = 64'h41 + 64'(k); exp_q.push_back(64'h41 + 64'(k));
            tick();
            chk("stream_ready", {63'd0, ready_o}, 64'd1);
        end
        valid_i = 1'b0;
        tick();
        chk("stream_end", {63'd0, valid_o}, 64'd0);
        ready_i = 1'b0;

        // Flush while full
        do_reset();
        valid_i = 1'b1; data_i = 64'hC;
        tick();
        data_i = 64'hD;
        tick();
        valid_i = 1'b0;
        chk("pre_flush_ready", {63'd0, ready_o}, 64'd0);
        flush_i = 1'b1;
        tick();
        flush_i = 1'b0;
        chk("flush_valid", {63'd0, valid_o}, 64'd0);
        chk("flush_data", data_o, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("flush_ready", {63'd0, ready_o}, 64'd1);
        chk("flush_cnt", {48'd0, flush_cnt_o}, STATS ? 64'd1 : 64'd0);

        // Stall with flush held for 3 cycles
        do_reset();
        valid_i = 1'b1; data_i = 64'h5; exp_q.push_back(64'h5);
        tick();
        valid_i = 1'b0; stall_i = 1'b1; flush_i = 1'b1; ready_i = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_data", data_o, 64'h5);
            chk("stall_valid", {63'd0, valid_o}, 64'd1);
        end
        chk("stall_scnt", {48'd0, stall_cnt_o}, STATS ? 64'd3 : 64'd0);
        chk("stall_fcnt", {48'd0, flush_cnt_o}, 64'd0);
        stall_i = 1'b0; flush_i = 1'b0;
        tick();
        chk("stall_drained", {63'd0, valid_o}, 64'd0);
        ready_i = 1'b0;

        // Asynchronous reset while full
        valid_i = 1'b1; data_i = 64'h21;
        tick();
        data_i = 64'h22;
        tick();
        valid_i = 1'b0;
        #3;
        rst_i = 1'b1;
        #1;
        chk("arst_valid", {63'd0, valid_o}, 64'd0);
        chk("arst_data", data_o, 64'd0);
        chk("arst_ready", {63'd0, ready_o}, 64'd1);
        chk("arst_scnt", {48'd0, stall_cnt_o}, 64'd0);
        chk("arst_fcnt", {48'd0, flush_cnt_o}, 64'd0);
        tick();
        rst_i = 1'b0;
        valid_i = 1'b1; data_i = 64'h33; ready_i = 1'b1; exp_q.push_back(64'h33);
        tick();
        valid_i = 1'b0;
        chk("post_rst_valid", {63'd0, valid_o}, 64'd1);
        chk("post_rst_data", data_o, 64'h33);
        tick();
        chk("post_rst_gone", {63'd0, valid_o}, 64'd0);
        ready_i = 1'b0;

        // Saturation on the 2-bit counter instance
        do_reset();
        v2 = 1'b1; d2 = 8'h07;
        tick();
        v2 = 1'b0; s2 = 1'b1;
        for (int k = 0; k < 5; k++) tick();
        chk("sat_scnt", {62'd0, scnt2}, STATS ? 64'd3 : 64'd0);
        chk("sat_data", {56'd0, dat_o2}, 64'h07);
        chk("sat_fcnt", {62'd0, fcnt2}, 64'd0);
        s2 = 1'b0;

        tick();
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Global time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1);
    end

endmodule
